// File: rtl/wide_add_sequencer.sv
// Multi-precision add sequencer: streams WORDS x 32-bit operand words through an
// external combinational 32-bit adder, LSW first, chaining carry and collecting the wide sum.
module wide_add_sequencer #(
    parameter int unsigned WORDS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [32*WORDS-1:0]   in_a,
    input  logic [32*WORDS-1:0]   in_b,
    input  logic                  in_cin,
    output logic [31:0]           add_a,
    output logic [31:0]           add_b,
    output logic                  add_cin,
    input  logic [31:0]           add_y,
    input  logic                  add_cout,
    input  logic                  add_ovf,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [32*WORDS-1:0]   out_sum,
    output logic                  out_cout,
    output logic                  out_ovf
);

    localparam int unsigned N     = 32 * WORDS;
    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [N-1:0]     a_q, a_d;
    logic [N-1:0]     b_q, b_d;
    logic [N-1:0]     sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;
    logic [31:0]      word_a, word_b;

    // Select the operand words addressed by idx
    always_comb begin
        word_a = '0;
        word_b = '0;
        for (int unsigned w = 0; w < WORDS; w++) begin
            if (idx_q == IDX_W'(w)) begin
                word_a = a_q[32*w +: 32];
                word_b = b_q[32*w +: 32];
            end
        end
    end

    assign add_a    = (state_q == RUN) ? word_a : 32'd0;
    assign add_b    = (state_q == RUN) ? word_b : 32'd0;
    assign add_cin  = (state_q == RUN) ? carry_q : 1'b0;
    assign in_ready = ~rst & (state_q == IDLE);

    assign out_valid = out_valid_q;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int unsigned w = 0; w < WORDS; w++) begin
                    if (idx_q == IDX_W'(w)) begin
                        sum_d[32*w +: 32] = add_y;
                    end
                end
                carry_d = add_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d  = add_cout;
                    ovf_d   = add_ovf;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed bench for wide_add_sequencer: WORDS=2 and WORDS=1 instances, each
// wired to a behavioural 32-bit combinational adder.
module tb_wide_add_sequencer;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   t_acc = 0;
    int   n_checks = 0;
    int   n_err = 0;
    int   lat;

    // WORDS=2 instance signals
    logic        in_valid2, in_ready2, in_cin2;
    logic [63:0] in_a2, in_b2;
    logic [31:0] add_a2, add_b2, add_y2;
    logic        add_cin2, add_cout2, add_ovf2;
    logic        out_valid2, out_ready2, out_cout2, out_ovf2;
    logic [63:0] out_sum2;

    // WORDS=1 instance signals
    logic        in_valid1, in_ready1, in_cin1;
    logic [31:0] in_a1, in_b1;
    logic [31:0] add_a1, add_b1, add_y1;
    logic        add_cin1, add_cout1, add_ovf1;
    logic        out_valid1, out_ready1, out_cout1, out_ovf1;
    logic [31:0] out_sum1;

    wide_add_sequencer #(.WORDS(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .in_a(in_a2), .in_b(in_b2), .in_cin(in_cin2),
        .add_a(add_a2), .add_b(add_b2), .add_cin(add_cin2),
        .add_y(add_y2), .add_cout(add_cout2), .add_ovf(add_ovf2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .out_sum(out_sum2), .out_cout(out_cout2), .out_ovf(out_ovf2)
    );

    wide_add_sequencer #(.WORDS(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .in_a(in_a1), .in_b(in_b1), .in_cin(in_cin1),
        .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1),
        .add_y(add_y1), .add_cout(add_cout1), .add_ovf(add_ovf1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_sum(out_sum1), .out_cout(out_cout1), .out_ovf(out_ovf1)
    );

    // Behavioural full_adder_32bit stand-ins
    always_comb begin
        {add_cout2, add_y2} = {1'b0, add_a2} + {1'b0, add_b2} + 33'(add_cin2);
        add_ovf2 = (add_a2[31] == add_b2[31]) && (add_y2[31] != add_a2[31]);
    end

    always_comb begin
        {add_cout1, add_y1} = {1'b0, add_a1} + {1'b0, add_b1} + 33'(add_cin1);
        add_ovf1 = (add_a1[31] == add_b1[31]) && (add_y1[31] != add_a1[31]);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept on the next edge; leaves the bench in the word-0 RUN cycle
    task automatic accept2(input logic [63:0] a, input logic [63:0] b, input logic cin);
        in_a2     = a;
        in_b2     = b;
        in_cin2   = cin;
        in_valid2 = 1'b1;
        step();
        t_acc     = cyc;
        in_valid2 = 1'b0;
    endtask

    task automatic wait_valid2(output int l);
        int k;
        k = 0;
        while (!out_valid2 && k < 20) begin
            step();
            k++;
        end
        l = out_valid2 ? (cyc - t_acc) : -1;
    endtask

    task automatic wait_valid1(output int l);
        int k;
        k = 0;
        while (!out_valid1 && k < 20) begin
            step();
            k++;
        end
        l = out_valid1 ? (cyc - t_acc) : -1;
    endtask

    task automatic take2();
        out_ready2 = 1'b1;
        step();
        out_ready2 = 1'b0;
        check("take_out_valid", 64'(out_valid2), 64'd0);
        check("take_in_ready", 64'(in_ready2), 64'd1);
    endtask

    initial begin
        rst = 1'b1;
        in_valid2 = 1'b0; in_a2 = '0; in_b2 = '0; in_cin2 = 1'b0; out_ready2 = 1'b0;
        in_valid1 = 1'b0; in_a1 = '0; in_b1 = '0; in_cin1 = 1'b0; out_ready1 = 1'b0;
        repeat (2) step();

        check("rst_in_ready", 64'(in_ready2), 64'd0);
        check("rst_out_valid", 64'(out_valid2), 64'd0);
        check("rst_out_sum", out_sum2, 64'd0);
        check("rst_add_a", 64'(add_a2), 64'd0);
        check("rst_add_cin", 64'(add_cin2), 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready2), 64'd1);

        // Carry propagates from word 0 into word 1
        accept2(64'h00000000_FFFFFFFF, 64'h00000000_00000001, 1'b0);
        check("t1_w0_add_cin", 64'(add_cin2), 64'd0);
        check("t1_w0_add_a", 64'(add_a2), 64'hFFFFFFFF);
        check("t1_w0_add_b", 64'(add_b2), 64'h1);
        step();
        check("t1_w1_add_cin", 64'(add_cin2), 64'd1);
        check("t1_w1_add_a", 64'(add_a2), 64'd0);
        wait_valid2(lat);
        check("t1_latency", 64'(lat), 64'd2);
        check("t1_sum", out_sum2, 64'h00000001_00000000);
        check("t1_cout", 64'(out_cout2), 64'd0);
        check("t1_ovf", 64'(out_ovf2), 64'd0);
        check("t1_done_add_a", 64'(add_a2), 64'd0);
        take2();

        // Signed overflow, then backpressure with a second set pending
        accept2(64'h7FFFFFFF_FFFFFFFF, 64'h1, 1'b0);
        wait_valid2(lat);
        check("t2_latency", 64'(lat), 64'd2);
        check("t2_sum", out_sum2, 64'h80000000_00000000);
        check("t2_cout", 64'(out_cout2), 64'd0);
        check("t2_ovf", 64'(out_ovf2), 64'd1);
        in_a2     = 64'hFFFFFFFF_FFFFFFFF;
        in_b2     = 64'h0;
        in_cin2   = 1'b1;
        in_valid2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_sum_stable", out_sum2, 64'h80000000_00000000);
            check("bp_in_ready", 64'(in_ready2), 64'd0);
            check("bp_out_valid", 64'(out_valid2), 64'd1);
        end
        check("bp_ovf_stable", 64'(out_ovf2), 64'd1);
        check("bp_cout_stable", 64'(out_cout2), 64'd0);
        out_ready2 = 1'b1;
        step();
        out_ready2 = 1'b0;
        check("bp_release_in_ready", 64'(in_ready2), 64'd1);
        check("bp_release_out_valid", 64'(out_valid2), 64'd0);
        step();
        t_acc     = cyc;
        in_valid2 = 1'b0;
        wait_valid2(lat);
        check("t3_latency", 64'(lat), 64'd2);
        check("t3_sum", out_sum2, 64'd0);
        check("t3_cout", 64'(out_cout2), 64'd1);
        check("t3_ovf", 64'(out_ovf2), 64'd0);
        take2();

        // Reset during the word-1 RUN cycle discards the transaction
        accept2(64'h00000001_00000005, 64'h00000002_00000006, 1'b0);
        step();
        rst = 1'b1;
        step();
        check("mid_rst_out_valid", 64'(out_valid2), 64'd0);
        check("mid_rst_out_sum", out_sum2, 64'd0);
        check("mid_rst_add_a", 64'(add_a2), 64'd0);
        check("mid_rst_add_b", 64'(add_b2), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready2), 64'd0);
        rst = 1'b0;
        #1;
        check("after_rst_in_ready", 64'(in_ready2), 64'd1);
        accept2(64'd3, 64'd4, 1'b0);
        wait_valid2(lat);
        check("t4_latency", 64'(lat), 64'd2);
        check("t4_sum", out_sum2, 64'd7);
        check("t4_cout", 64'(out_cout2), 64'd0);
        take2();

        // Single-word instance
        check("w1_in_ready", 64'(in_ready1), 64'd1);
        in_a1     = 32'h80000000;
        in_b1     = 32'h80000000;
        in_cin1   = 1'b0;
        in_valid1 = 1'b1;
        step();
        t_acc     = cyc;
        in_valid1 = 1'b0;
        check("w1_run_add_a", 64'(add_a1), 64'h80000000);
        check("w1_run_in_ready", 64'(in_ready1), 64'd0);
        wait_valid1(lat);
        check("w1_latency", 64'(lat), 64'd1);
        check("w1_sum", 64'(out_sum1), 64'd0);
        check("w1_cout", 64'(out_cout1), 64'd1);
        check("w1_ovf", 64'(out_ovf1), 64'd1);
        out_ready1 = 1'b1;
        step();
        out_ready1 = 1'b0;
        check("w1_take_out_valid", 64'(out_valid1), 64'd0);
        check("w1_take_in_ready", 64'(in_ready1), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
